// File: rtl/keypad_if.sv
// Pin-side bundle of the keypad scanner: row sense in, column drive and key events out.
// state mirrors the scanner FSM (0 SCAN, 1 DEBOUNCE, 2 HELD, 3 RELEASE) for observation.
interface keypad_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 3,
    parameter int CODE_W = 4
);
    logic [ROWS-1:0]   r;
    logic [COLS-1:0]   c;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_held;
    logic              multi_err;
    logic [1:0]        state;

    modport master (
        input  r,
        output c, key_valid, key_code, key_held, multi_err, state
    );

    modport slave (
        output r,
        input  c, key_valid, key_code, key_held, multi_err, state
    );
endinterface

// File: rtl/keypad_scanner.sv
// Column-at-a-time scanner for an active-low ROWS x COLS key matrix with press and
// release debounce; reports each press once as key_valid + key_code, flags multi-key columns.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 8,
    parameter int CODE_W   = 4
) (
    input logic      clk,
    input logic      reset,
    keypad_if.master kp
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ZC_W  = $clog2(ROWS + 1);
    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);

    if (COLS < 2 || ROWS < 1 || DWELL < 1 || DEBOUNCE < 1 || (2 ** CODE_W) < ROWS * COLS) begin : g_bad_params
        $fatal(1, "keypad_scanner: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        DEB     = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [COLS-1:0]   c_q;
    logic [DW_W-1:0]   dwell;
    logic [DB_W-1:0]   cnt;
    logic [ROWS-1:0]   pattern;
    logic [ROW_W-1:0]  row;
    logic [ROWS-1:0]   stale;
    logic              key_valid_q;
    logic [CODE_W-1:0] key_code_q;
    logic              key_held_q;
    logic              multi_err_q;

    logic [ZC_W-1:0]   zeros;
    logic [ROW_W-1:0]  row_hit;
    logic [COL_W-1:0]  col_inc;
    logic [COLS-1:0]   c_inc;

    always_comb begin
        zeros   = '0;
        row_hit = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!kp.r[i]) begin
                zeros   = zeros + ZC_W'(1);
                row_hit = ROW_W'(i);
            end
        end
    end

    assign col_inc = (col == COL_W'(COLS - 1)) ? '0 : col + COL_W'(1);
    assign c_inc   = ~(COLS'(1) << col_inc);

    // stale marks column-0 keys already down at reset; they stay ignored until seen released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN;
            col         <= '0;
            c_q         <= ~COLS'(1);
            dwell       <= '0;
            cnt         <= '0;
            pattern     <= '1;
            row         <= '0;
            stale       <= c_q[0] ? '0 : ~kp.r;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DW_W'(DWELL - 1)) begin
                        dwell <= '0;
                        if (col == '0) stale <= stale & ~kp.r;
                        if (zeros == '0 || (zeros == ZC_W'(1) && col == '0 && stale[row_hit])) begin
                            col <= col_inc;
                            c_q <= c_inc;
                        end else if (zeros == ZC_W'(1)) begin
                            pattern <= kp.r;
                            row     <= row_hit;
                            cnt     <= '0;
                            state   <= DEB;
                        end else begin
                            multi_err_q <= 1'b1;
                            cnt         <= '0;
                            state       <= RELEASE;
                        end
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end
                DEB: begin
                    if (kp.r != pattern) begin
                        dwell <= '0;
                        state <= SCAN;
                    end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= CODE_W'(int'(col) * ROWS + int'(row));
                        key_held_q  <= 1'b1;
                        state       <= HELD;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (&kp.r) begin
                        key_held_q <= 1'b0;
                        cnt        <= '0;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!(&kp.r)) begin
                        cnt <= '0;
                    end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
                        dwell <= '0;
                        col   <= col_inc;
                        c_q   <= c_inc;
                        state <= SCAN;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign kp.c         = c_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
    assign kp.multi_err = multi_err_q;
    assign kp.state     = state;
endmodule
